// File: rtl/logic_pkg.sv
// Shared types and constants for the logical-op issuer and its decoder.
package logic_pkg;

    typedef enum logic [1:0] {
        ALU_AND  = 2'b00,
        ALU_OR   = 2'b01,
        ALU_XOR  = 2'b10,
        ALU_NONE = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StResp  = 2'b10
    } issuer_state_e;

endpackage

// File: rtl/logic_op_issuer_if.sv
// Request / logic-unit / response bundle for logic_op_issuer.
// LOGIC_OP_ISSUER_STATS_EN adds the o_op_count retirement counter output.
interface logic_op_issuer_if;
    import logic_pkg::*;

    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_imm;
    logic        i_use_imm;

    logic [31:0] o_operand_a;
    logic [31:0] o_operand_b;
    alu_op_e     o_alu_op;
    logic [31:0] i_logic_result;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_illegal;

`ifdef LOGIC_OP_ISSUER_STATS_EN
    logic [15:0] o_op_count;
`endif

    // Requester side: also stands in for the external logic unit and the response consumer.
    modport master (
`ifdef LOGIC_OP_ISSUER_STATS_EN
        input  o_op_count,
`endif
        output i_req_valid, i_funct3, i_rs1_data, i_rs2_data, i_imm, i_use_imm,
        output i_logic_result, i_rsp_ready,
        input  o_req_ready, o_operand_a, o_operand_b, o_alu_op,
        input  o_rsp_valid, o_rsp_data, o_rsp_illegal
    );

    modport slave (
`ifdef LOGIC_OP_ISSUER_STATS_EN
        output o_op_count,
`endif
        input  i_req_valid, i_funct3, i_rs1_data, i_rs2_data, i_imm, i_use_imm,
        input  i_logic_result, i_rsp_ready,
        output o_req_ready, o_operand_a, o_operand_b, o_alu_op,
        output o_rsp_valid, o_rsp_data, o_rsp_illegal
    );

endinterface

// File: rtl/logic_op_decode.sv
// Combinational funct3 decoder: maps RISC-V logical funct3 to an ALU opcode.
module logic_op_decode
    import logic_pkg::*;
(
    input  logic [2:0] funct3,
    output alu_op_e    alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_NONE;
        illegal = 1'b1;
        case (funct3)
            F3_AND: begin
                alu_op  = ALU_AND;
                illegal = 1'b0;
            end
            F3_OR: begin
                alu_op  = ALU_OR;
                illegal = 1'b0;
            end
            F3_XOR: begin
                alu_op  = ALU_XOR;
                illegal = 1'b0;
            end
            default: begin
                alu_op  = ALU_NONE;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_issuer.sv
// Issues one logical op to an external logic unit and returns its result.
// LOGIC_OP_ISSUER_STATS_EN adds a 16-bit wrapping count of retired responses.
module logic_op_issuer
    import logic_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    logic_op_issuer_if.slave    bus
);

    alu_op_e       dec_alu_op;
    logic          dec_illegal;

    issuer_state_e state_q;
    logic [31:0]   operand_a_q;
    logic [31:0]   operand_b_q;
    alu_op_e       alu_op_q;
    logic          illegal_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_valid_q;
    logic          rsp_illegal_q;

    logic          req_ready;
    logic          accept;

    logic_op_decode u_decode (
        .funct3  (bus.i_funct3),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    // In RESP a new request may only enter on the edge the current response retires.
    always_comb begin
        req_ready = 1'b0;
        if (!i_reset) begin
            case (state_q)
                StIdle:  req_ready = 1'b1;
                StResp:  req_ready = bus.i_rsp_ready;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign accept = bus.i_req_valid & req_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= StIdle;
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            alu_op_q      <= ALU_NONE;
            illegal_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                operand_a_q <= bus.i_rs1_data;
                operand_b_q <= bus.i_use_imm ? bus.i_imm : bus.i_rs2_data;
                alu_op_q    <= dec_alu_op;
                illegal_q   <= dec_illegal;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    rsp_data_q    <= illegal_q ? '0 : bus.i_logic_result;
                    rsp_illegal_q <= illegal_q;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= StResp;
                end
                StResp: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? StIssue : StIdle;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

`ifdef LOGIC_OP_ISSUER_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_count_q <= '0;
        end else if (rsp_valid_q && bus.i_rsp_ready) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign bus.o_op_count = op_count_q;
`endif

    assign bus.o_req_ready   = req_ready;
    assign bus.o_operand_a   = operand_a_q;
    assign bus.o_operand_b   = operand_b_q;
    assign bus.o_alu_op      = alu_op_q;
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_data    = rsp_data_q;
    assign bus.o_rsp_illegal = rsp_illegal_q;

endmodule
